// File: rtl/pwm_42_pkg.sv
// Shared types and constants for the pwm_42 phase-leg PWM generator.
package pwm_42_pkg;

  localparam int DUTY_W       = 4;
  localparam int PERIOD_TICKS = 15;
  localparam int CNT_MAX      = PERIOD_TICKS - 1;

  typedef logic [DUTY_W-1:0] duty_t;
  typedef logic [3:0]        cnt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Output level for a given (next) state: high while the tick counter is below the duty code.
  function automatic logic pwm_level(input logic run, input cnt_t cnt, input duty_t duty);
    return run && (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_42_prescaler.sv
// Clock prescaler: tick is high on the last clock of each PRESCALE-clock group.
module pwm_42_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_q;
  logic [PW-1:0] count_n;

  always_comb begin
    count_n = count_q + 1'b1;
    if (clr || (count_q == LAST)) count_n = '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) count_q <= '0;
    else        count_q <= count_n;
  end

  // tick_next lets the owner register outputs that depend on the tick of the following clock.
  assign tick      = (count_q == LAST);
  assign tick_next = (count_n == LAST);

endmodule

// File: rtl/pwm_42.sv
// 4-bit duty PWM for one BLDC phase leg: 15-tick period, registered P and period-end strobe X.
module pwm_42
  import pwm_42_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic  CLK,
  input  logic  RST_N,
  input  duty_t D,
  input  logic  E,
  output logic  P,
  output logic  X
);

  run_state_t state_q, state_n;
  cnt_t       cnt_q, cnt_n;
  duty_t      duty_q, duty_n;
  logic       p_q, p_n;
  logic       x_q, x_n;
  logic       tick, tick_next, clr, run_n;

  pwm_42_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (clr),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    duty_n  = duty_q;
    if (!E) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      duty_n  = D;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_RUN;
          cnt_n   = '0;
          duty_n  = D;
        end
        ST_RUN: begin
          // Duty only reloads at the wrap so a mid-period D change never makes a runt pulse.
          if (tick) begin
            if (cnt_q == cnt_t'(CNT_MAX)) begin
              cnt_n  = '0;
              duty_n = D;
            end else begin
              cnt_n = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          duty_n  = D;
        end
      endcase
    end
  end

  // Prescaler restarts from zero while idle and on the starting edge.
  assign clr   = (state_q != ST_RUN) || (state_n != ST_RUN);
  assign run_n = (state_n == ST_RUN);

  always_comb begin
    p_n = pwm_level(run_n, cnt_n, duty_n);
    x_n = run_n && (cnt_n == cnt_t'(CNT_MAX)) && tick_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      p_q     <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      duty_q  <= duty_n;
      p_q     <= p_n;
      x_q     <= x_n;
    end
  end

  assign P = p_q;
  assign X = x_q;

endmodule

// File: tb/tb_pwm_42.sv
// Scoreboard bench for pwm_42 with PRESCALE=1 and PRESCALE=3 instances side by side.
module tb_pwm_42;
  import pwm_42_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  e1, e3;
  duty_t d1, d3;
  logic  p1, x1, p3, x3;

  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int pos1     = 0;

  // clock / reset
  always #5 clk = ~clk;

  pwm_42 #(.PRESCALE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .D(d1), .E(e1), .P(p1), .X(x1)
  );

  pwm_42 #(.PRESCALE(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .D(d3), .E(e3), .P(p3), .X(x3)
  );

  // monitor: every clock with a pending expectation is compared #1 after the edge
  initial begin
    logic [3:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({p1, x1, p3, x3} !== exp) begin
          failures++;
          $display("FAIL outputs t=%0t got p1x1p3x3=%b required=%b", $time, {p1, x1, p3, x3}, exp);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s t=%0t got=%b required=%b", name, $time, got, req);
    end
  endtask

  // driver: inputs change on the falling edge, expectation queued at the rising edge
  task automatic step(input logic ev1, input duty_t dv1, input logic ev3, input duty_t dv3,
                      input logic [3:0] exp);
    @(negedge clk);
    e1 = ev1; d1 = dv1; e3 = ev3; d3 = dv3;
    @(posedge clk);
    exp_q.push_back(exp);
  endtask

  // PRESCALE=1 instance running; exp_duty is the duty in force for these clocks
  task automatic run1(input duty_t drv, input duty_t exp_duty, input int n);
    for (int i = 0; i < n; i++) begin
      logic p, x;
      p = (pos1 < int'(exp_duty));
      x = (pos1 == CNT_MAX);
      step(1'b1, drv, 1'b0, 4'd0, {p, x, 2'b00});
      pos1 = (pos1 + 1) % PERIOD_TICKS;
    end
  endtask

  // PRESCALE=3 instance running from a fresh start, PRESCALE=1 instance idle
  task automatic run3(input duty_t duty, input int n);
    for (int i = 0; i < n; i++) begin
      int   c, ps;
      logic p, x;
      c  = (i / 3) % PERIOD_TICKS;
      ps = i % 3;
      p  = (c < int'(duty));
      x  = (c == CNT_MAX) && (ps == 2);
      step(1'b0, 4'd0, 1'b1, duty, {2'b00, p, x});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; e1 = 1'b1; d1 = 4'd7; e3 = 1'b0; d3 = 4'd0;
    #1;
    check_now("reset_p1", p1, 1'b0);
    check_now("reset_x1", x1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd7, 1'b0, 4'd0, 4'b0000);
    #2 rst_n = 1'b1;

    pos1 = 0;
    run1(4'd7, 4'd7, 15);    // P high 7, X on clock 15
    run1(4'd0, 4'd0, 45);    // D=0: never high, X at 15/30/45
    run1(4'd15, 4'd15, 45);  // D=15: high across wraps
    run1(4'd5, 4'd5, 30);    // D=5: 5 high, 10 low
    run1(4'd5, 4'd5, 3);     // change 5->10 at clock 3
    run1(4'd10, 4'd5, 12);
    run1(4'd10, 4'd10, 15);

    run1(4'd12, 4'd12, 7);   // drop E at clock 7
    for (int i = 0; i < 3; i++) step(1'b0, 4'd12, 1'b0, 4'd0, 4'b0000);
    pos1 = 0;
    run1(4'd12, 4'd12, 15);  // fresh period from cnt=0

    run1(4'd12, 4'd12, 5);   // async reset mid-period
    #2;
    check_now("mid_p1_before_reset", p1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_now("async_reset_p1", p1, 1'b0);
    check_now("async_reset_x1", x1, 1'b0);
    step(1'b0, 4'd12, 1'b0, 4'd0, 4'b0000);
    #2 rst_n = 1'b1;
    step(1'b0, 4'd12, 1'b0, 4'd0, 4'b0000);

    run3(4'd5, 90);          // PRESCALE=3: 15 high, 30 low, X every 45

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
